// File: rtl/btn_event_source_if.sv
// Button front-end bundle: raw buttons and the frame handshake in,
// debounced level, edge, latched events and hold speed out.
interface btn_event_source_if #(
  parameter int NBTN = 5
);
  logic [NBTN-1:0]   btn_raw;
  logic              frame;
  logic              clr;
  logic [NBTN-1:0]   level;
  logic [NBTN-1:0]   down;
  logic [NBTN-1:0]   once;
  logic [NBTN-1:0]   rep;
  logic [2*NBTN-1:0] mag;

  modport master (
    output btn_raw, frame, clr,
    input  level, down, once, rep, mag
  );

  modport slave (
    input  btn_raw, frame, clr,
    output level, down, once, rep, mag
  );
endinterface

// File: rtl/btn_event_source.sv
// Per-button synchronizer, debouncer, press edge and frame-paced auto-repeat.
// Define BTN_FAST_REPEAT_EN to build the FAST repeat state (mag=3).
module btn_event_source #(
  parameter int NBTN          = 5,
  parameter int DEB_CYCLES    = 200000,
  parameter int DEB_W         = 18,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 4,
  parameter int FAST_AFTER    = 16
) (
  input  logic               clk,
  input  logic               rst,
  btn_event_source_if.slave  bus
);

  localparam int FMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int FCNT_W = $clog2(FMAX + 1);
`ifdef BTN_FAST_REPEAT_EN
  localparam int SCNT_W = $clog2(FAST_AFTER + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
`ifdef BTN_FAST_REPEAT_EN
    S_SLOW  = 2'd2,
    S_FAST  = 2'd3
`else
    S_SLOW  = 2'd2
`endif
  } state_t;

`ifndef BTN_FAST_REPEAT_EN
  // FAST_AFTER has no effect unless the fast-repeat state is built.
  if (FAST_AFTER < 0) begin : g_fast_after_unused
  end
`endif

  genvar gi;
  for (gi = 0; gi < NBTN; gi++) begin : g_btn
    logic [1:0]        r_sync;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_level;
    logic              r_down;
    logic              r_fall;
    state_t            r_state;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_inc;
    logic [1:0]        r_mag;
    logic              r_once;
    logic              r_rep;

    // r_down/r_fall mark the cycle in which level first shows its new value.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync    <= 2'b00;
        r_deb_cnt <= '0;
        r_level   <= 1'b0;
        r_down    <= 1'b0;
        r_fall    <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], bus.btn_raw[gi]};
        r_down <= 1'b0;
        r_fall <= 1'b0;
        if (r_sync[1] == r_level) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb_cnt <= '0;
          r_level   <= ~r_level;
          r_down    <= ~r_level;
          r_fall    <= r_level;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end

    assign w_fcnt_inc = (r_fcnt == {FCNT_W{1'b1}}) ? r_fcnt : r_fcnt + 1'b1;

`ifdef BTN_FAST_REPEAT_EN
    logic [SCNT_W-1:0] r_scnt;
    logic [SCNT_W-1:0] w_scnt_inc;
    assign w_scnt_inc = (r_scnt == {SCNT_W{1'b1}}) ? r_scnt : r_scnt + 1'b1;
`endif

    // clr is applied first so that any set later in the block overrides it.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_fcnt  <= '0;
        r_mag   <= 2'd0;
        r_once  <= 1'b0;
        r_rep   <= 1'b0;
`ifdef BTN_FAST_REPEAT_EN
        r_scnt  <= '0;
`endif
      end else begin
        if (bus.clr) begin
          r_once <= 1'b0;
          r_rep  <= 1'b0;
        end
        if (r_fall) begin
          r_state <= S_IDLE;
          r_mag   <= 2'd0;
          r_fcnt  <= '0;
`ifdef BTN_FAST_REPEAT_EN
          r_scnt  <= '0;
`endif
        end else begin
          case (r_state)
            S_IDLE: begin
              if (r_down) begin
                r_once  <= 1'b1;
                r_rep   <= 1'b1;
                r_fcnt  <= '0;
                r_state <= S_DELAY;
                r_mag   <= 2'd1;
              end
            end
            S_DELAY: begin
              if (bus.frame) begin
                if (w_fcnt_inc == FCNT_W'(REPEAT_DELAY)) begin
                  r_rep   <= 1'b1;
                  r_fcnt  <= '0;
                  r_state <= S_SLOW;
                  r_mag   <= 2'd2;
                end else begin
                  r_fcnt <= w_fcnt_inc;
                end
              end
            end
            S_SLOW: begin
              if (bus.frame) begin
                if (w_fcnt_inc == FCNT_W'(REPEAT_PERIOD)) begin
                  r_rep  <= 1'b1;
                  r_fcnt <= '0;
`ifdef BTN_FAST_REPEAT_EN
                  r_scnt <= w_scnt_inc;
                  if (w_scnt_inc == SCNT_W'(FAST_AFTER)) begin
                    r_state <= S_FAST;
                    r_mag   <= 2'd3;
                  end
`endif
                end else begin
                  r_fcnt <= w_fcnt_inc;
                end
              end
            end
`ifdef BTN_FAST_REPEAT_EN
            S_FAST: begin
              if (bus.frame) begin
                r_rep <= 1'b1;
              end
            end
`endif
            default: begin
              r_state <= S_IDLE;
              r_mag   <= 2'd0;
            end
          endcase
        end
      end
    end

    assign bus.level[gi]       = r_level;
    assign bus.down[gi]        = r_down;
    assign bus.once[gi]        = r_once;
    assign bus.rep[gi]         = r_rep;
    assign bus.mag[2*gi +: 2]  = r_mag;
  end

endmodule

// File: tb/tb_btn_event_source.sv
// Bench for btn_event_source: fixed vector table, hand-written corner sequences
// and a long random run, all compared against a frame-count reference model.
module tb_btn_event_source;
  localparam int NBTN = 5;
  localparam int DEB  = 4;
  localparam int RD   = 3;
  localparam int RP   = 2;
  localparam int FA   = 2;
`ifdef BTN_FAST_REPEAT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_event_source_if #(.NBTN(NBTN)) bus ();

  btn_event_source #(
    .NBTN(NBTN), .DEB_CYCLES(DEB), .DEB_W(3),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FAST_AFTER(FA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: debounce as a run of mismatching samples, repeat
  // behaviour as a pure function of frames seen since the press.
  logic [1:0] m_sync [NBTN];
  int         m_run  [NBTN];
  bit         m_level[NBTN];
  bit         m_down [NBTN];
  bit         m_fall [NBTN];
  bit         m_held [NBTN];
  int         m_nfr  [NBTN];
  bit         m_once [NBTN];
  bit         m_rep  [NBTN];

  function automatic bit rep_due(int n);
    if (n < RD) return 1'b0;
    if (n == RD) return 1'b1;
    if (FAST && n > RD + FA * RP) return 1'b1;
    return ((n - RD) % RP) == 0;
  endfunction

  function automatic logic [1:0] mag_of(bit held, int n);
    if (!held) return 2'd0;
    if (n < RD) return 2'd1;
    if (FAST && n >= RD + FA * RP) return 2'd3;
    return 2'd2;
  endfunction

  function automatic void model_step();
    for (int b = 0; b < NBTN; b++) begin
      bit set_o, set_r, nd, nf;
      set_o = 1'b0; set_r = 1'b0; nd = 1'b0; nf = 1'b0;
      if (rst) begin
        m_sync[b] = 2'b00; m_run[b] = 0; m_level[b] = 0; m_down[b] = 0;
        m_fall[b] = 0; m_held[b] = 0; m_nfr[b] = 0; m_once[b] = 0; m_rep[b] = 0;
      end else begin
        if (m_fall[b]) begin
          m_held[b] = 0; m_nfr[b] = 0;
        end else if (!m_held[b]) begin
          if (m_down[b]) begin
            m_held[b] = 1; m_nfr[b] = 0; set_o = 1; set_r = 1;
          end
        end else if (bus.frame) begin
          m_nfr[b] = m_nfr[b] + 1;
          set_r = rep_due(m_nfr[b]);
        end
        m_once[b] = (m_once[b] && !bus.clr) || set_o;
        m_rep[b]  = (m_rep[b]  && !bus.clr) || set_r;
        if (m_sync[b][1] != m_level[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DEB) begin
            m_level[b] = !m_level[b];
            nd = m_level[b];
            nf = !m_level[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_down[b] = nd;
        m_fall[b] = nf;
        m_sync[b] = {m_sync[b][0], bus.btn_raw[b]};
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    logic [NBTN-1:0]   el, ed, eo, er;
    logic [2*NBTN-1:0] em;
    for (int b = 0; b < NBTN; b++) begin
      el[b] = m_level[b]; ed[b] = m_down[b]; eo[b] = m_once[b]; er[b] = m_rep[b];
      em[2*b +: 2] = mag_of(m_held[b], m_nfr[b]);
    end
    chk("model_level", 32'(bus.level), 32'(el));
    chk("model_down",  32'(bus.down),  32'(ed));
    chk("model_once",  32'(bus.once),  32'(eo));
    chk("model_rep",   32'(bus.rep),   32'(er));
    chk("model_mag",   32'(bus.mag),   32'(em));
  endtask

  task automatic tick(input bit fr);
    bus.frame = fr;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_model();
  endtask

  typedef struct {
    logic [4:0] raw;
    logic       clr;
    logic [4:0] e_level;
    logic [4:0] e_down;
    logic [4:0] e_once;
    logic [4:0] e_rep;
    logic [9:0] e_mag;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] intent;
    logic [4:0] glitch;
    bit [8:1]   rep_pat;
    logic [1:0] mag_pat [1:8];

    // Button 0 pressed for 8 cycles with a clr, button 2 bouncing in 3-cycle bursts.
    for (int i = 0; i < 20; i++) begin
      vecs[i].raw     = {2'b00, (i % 4 != 3), 1'b0, (i < 8)};
      vecs[i].clr     = (i == 7);
      vecs[i].e_level = {4'b0000, (i >= 5 && i <= 12)};
      vecs[i].e_down  = {4'b0000, (i == 5)};
      vecs[i].e_once  = {4'b0000, (i == 6)};
      vecs[i].e_rep   = {4'b0000, (i == 6)};
      vecs[i].e_mag   = (i >= 6 && i <= 13) ? 10'd1 : 10'd0;
    end
    rep_pat = FAST ? 8'b1101_0100 : 8'b0101_0100;
    mag_pat[1] = 2'd1; mag_pat[2] = 2'd1;
    for (int k = 3; k <= 6; k++) mag_pat[k] = 2'd2;
    mag_pat[7] = FAST ? 2'd3 : 2'd2;
    mag_pat[8] = FAST ? 2'd3 : 2'd2;

    rst = 1'b1; bus.btn_raw = '0; bus.frame = 1'b0; bus.clr = 1'b0;
    tick(0); tick(0);
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_down",  32'(bus.down),  32'd0);
    chk("reset_once",  32'(bus.once),  32'd0);
    chk("reset_rep",   32'(bus.rep),   32'd0);
    chk("reset_mag",   32'(bus.mag),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.btn_raw = vecs[i].raw;
      bus.clr     = vecs[i].clr;
      tick(0);
      chk("vec_level", 32'(bus.level), 32'(vecs[i].e_level));
      chk("vec_down",  32'(bus.down),  32'(vecs[i].e_down));
      chk("vec_once",  32'(bus.once),  32'(vecs[i].e_once));
      chk("vec_rep",   32'(bus.rep),   32'(vecs[i].e_rep));
      chk("vec_mag",   32'(bus.mag),   32'(vecs[i].e_mag));
      $display("vec %0d raw=%b clr=%b level=%b down=%b once=%b rep=%b mag=%b",
               i, vecs[i].raw, vecs[i].clr, bus.level, bus.down, bus.once, bus.rep, bus.mag);
    end
    bus.clr = 1'b0;

    // Press registered in the same cycle as clr: the set must survive.
    bus.btn_raw = 5'b00001;
    n = 0;
    while (!bus.down[0] && n < 20) begin tick(0); n++; end
    chk("s5_down_seen", 32'(bus.down[0]), 32'd1);
    bus.clr = 1'b1; tick(0); bus.clr = 1'b0;
    chk("s5_once_kept", 32'(bus.once[0]), 32'd1);
    bus.clr = 1'b1; tick(0); bus.clr = 1'b0;
    chk("s5_once_cleared", 32'(bus.once[0]), 32'd0);
    bus.btn_raw = 5'b00000;
    repeat (12) tick(0);
    $display("seq press_vs_clr done cyc=%0d", cyc);

    // Button 1 held for 8 frames, clr after each frame.
    bus.btn_raw = 5'b00010;
    n = 0;
    while (!bus.once[1] && n < 20) begin tick(0); n++; end
    chk("s3_press_rep", 32'(bus.rep[1]), 32'd1);
    chk("s3_press_mag", 32'(bus.mag[3:2]), 32'd1);
    bus.clr = 1'b1; tick(0); bus.clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      repeat (8) tick(0);
      tick(1);
      chk("s3_frame_rep", 32'(bus.rep[1]), 32'(rep_pat[k]));
      chk("s3_frame_mag", 32'(bus.mag[3:2]), 32'(mag_pat[k]));
      bus.clr = 1'b1; tick(0); bus.clr = 1'b0;
      chk("s3_clr_rep", 32'(bus.rep[1]), 32'd0);
    end
    bus.btn_raw = 5'b00000;
    n = 0;
    while (bus.level[1] && n < 20) begin tick(0); n++; end
    chk("s3_mag_at_fall", 32'(bus.mag[3:2]), 32'(mag_pat[8]));
    tick(0);
    chk("s3_mag_after_fall", 32'(bus.mag[3:2]), 32'd0);
    repeat (4) tick(0);
    $display("seq hold_repeat done cyc=%0d fast=%0d", cyc, FAST);

    // Reset while button 4 is in slow repeat; it must re-report after release.
    bus.btn_raw = 5'b10000;
    n = 0;
    while (!bus.once[4] && n < 20) begin tick(0); n++; end
    for (int k = 0; k < 3; k++) begin repeat (8) tick(0); tick(1); tick(0); end
    chk("s6_slow_mag", 32'(bus.mag[9:8]), 32'd2);
    rst = 1'b1; tick(0); rst = 1'b0;
    chk("s6_rst_level", 32'(bus.level), 32'd0);
    chk("s6_rst_down",  32'(bus.down),  32'd0);
    chk("s6_rst_once",  32'(bus.once),  32'd0);
    chk("s6_rst_rep",   32'(bus.rep),   32'd0);
    chk("s6_rst_mag",   32'(bus.mag),   32'd0);
    n = 0;
    while (!bus.down[4] && n < 30) begin tick(0); n++; end
    chk("s6_redown_latency", 32'(n), 32'(DEB + 2));
    bus.btn_raw = 5'b00000;
    repeat (12) tick(0);
    $display("seq reset_in_slow done cyc=%0d", cyc);

    // Random held/bouncing buttons, free-running frames, random clr and reset.
    intent = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NBTN; b++) begin
        if ($urandom_range(0, 59) == 0) intent[b] = ~intent[b];
        glitch[b] = ($urandom_range(0, 24) == 0);
      end
      bus.btn_raw = intent ^ glitch;
      bus.clr     = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 799) == 0);
      tick(cyc % 10 == 9);
      if (c % 500 == 499)
        $display("random block %0d cyc=%0d errors=%0d", c / 500, cyc, errors);
    end
    rst = 1'b0; bus.clr = 1'b0; bus.btn_raw = '0;
    repeat (4) tick(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_source.md
Name: btn_event_source

Overview:
Per-button front end that produces the button event stream consumed by the per-frame control FSM. It turns raw, bouncing push-button inputs into four outputs per button: a debounced level, a single-cycle press edge, frame-handshaked event latches, and a hold-speed magnitude. Its `level`, `down`, `once` and `mag` outputs drive the control core's button inputs directly, and the core's DONE-state strobe clears the latches once per frame.

Parameters:
- NBTN, 5, number of buttons (L, R, U, D, C order, LSB first).
- DEB_CYCLES, 200000, consecutive stable clk cycles required to accept a level change (5 ms at 40 MHz pixel clock).
- DEB_W, 18, debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.
- REPEAT_DELAY, 30, frames a button is held before auto-repeat starts.
- REPEAT_PERIOD, 4, frames between auto-repeat events in slow repeat.
- FAST_AFTER, 16, slow repeat events before fast repeat (optional feature only).

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- btn_raw  in  NBTN  asynchronous raw button inputs, active-high
- frame  in  1  one-cycle start-of-frame tick from the VGA timing generator
- clr  in  1  one-cycle frame-consumed strobe from the control FSM
- level  out  NBTN  debounced button level
- down  out  NBTN  one-cycle pulse on each debounced rising edge
- once  out  NBTN  press event latch; held until clr
- rep  out  NBTN  step event latch (press or auto-repeat); held until clr
- mag  out  2*NBTN  hold speed per button, bits [2i+1:2i]

Behaviour:
- Reset values: level, down, once, rep and mag are all 0; synchronizers, counters and FSMs are cleared. A reset asserted mid-operation aborts everything in the same cycle.
- Synchronization: two flip-flop synchronizer per bit; reset value 0.
- Debounce:
  - The counter clears whenever the synchronized value equals level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1, level toggles and the counter clears.
  - A raw change held stable appears on level exactly DEB_CYCLES+2 cycles later.
  - A glitch shorter than DEB_CYCLES cycles never changes level.
  - A button held through reset produces a normal press after DEB_CYCLES+2 cycles.
- down: registered; high for exactly the cycle in which level first reads 1.
- Per-button FSM states: IDLE, DELAY, SLOW, FAST.
  - IDLE, on a level rising edge: set once and rep, clear the frame counter, go to DELAY.
  - DELAY, on each frame: increment the frame counter. When the count reaches REPEAT_DELAY, set rep, clear the counter and go to SLOW.
  - SLOW, on each frame: increment the counter. When it reaches REPEAT_PERIOD, set rep and clear the counter. Count slow repeats; see the optional feature for the SLOW to FAST transition.
  - FAST: set rep on every frame tick.
  - In any state, a level falling edge returns to IDLE in the next cycle and clears the counters. Latches already set stay set until clr.
- mag: 0 in IDLE, 1 in DELAY, 2 in SLOW, 3 in FAST. Registered together with the state.
- Latch handshake:
  - clr clears once and rep for all buttons.
  - If a set condition and clr occur in the same cycle, the set wins, so no event is lost.
  - Multiple events within one frame merge into a single asserted latch; there is no count.
- Frame counter: width is ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)); it saturates and never wraps.
- Buttons are fully independent; simultaneous presses on several buttons are all reported in the same cycle.
- frame and clr in the same cycle: frame processing (a possible set) and clr both apply, and set wins per the latch handshake rule.

Optional Feature:
- Macro: BTN_FAST_REPEAT_EN.
- Defined: in SLOW, after FAST_AFTER repeat events, go to FAST, where mag=3 and rep is set every frame.
- Undefined: the FAST state is not built, SLOW persists until release, mag never exceeds 2, and FAST_AFTER is ignored.

Test Plan:
Simulation parameters for all scenarios: DEB_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, FAST_AFTER=2, frame every 10 cycles.
1. btn_raw[0] rises at cycle 0 and is held -> level[0]=1 and down[0]=1 at cycle 6 only; once[0]=1 and rep[0]=1 from cycle 7; mag[1:0]=1.
2. btn_raw[2] pulses high for 3 cycles with 1-cycle bounces over 20 cycles -> level, down, once and rep for button 2 stay 0.
3. Hold button 1 for 8 frames with clr after each frame -> rep at the press, then on the 3rd frame tick (mag=2), then every 2nd frame. Release -> mag=0 one cycle after level falls.
4. With BTN_FAST_REPEAT_EN, hold button 3 -> after 2 slow repeats mag=3 and rep is re-set on every frame despite clr each frame. Without the macro -> mag stays 2.
5. Press event and clr in the same cycle -> once stays 1 afterwards; the next clr clears it to 0.
6. Assert rst for 1 cycle while button 4 is in SLOW -> all outputs are 0 the next cycle; the still-held button re-reports down after DEB_CYCLES+2 cycles.
